// File: rtl/reg_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// reg_scoreboard_pkg
//   Shared constants for the DE-stage register scoreboard. These mirror the
//   pipeline-wide defines: register-number width, register count, default
//   pending-write counter width and the DE->FE control bus width.
// -----------------------------------------------------------------------------
package reg_scoreboard_pkg;

    localparam int REGNOBITS     = 5;   // architectural register-number width
    localparam int REGWORDS      = 32;  // architectural register count
    localparam int SB_CNTBITS    = 2;   // pending writes tracked per register
    localparam int SB_TOTBITS    = 7;   // holds REGWORDS * (2**SB_CNTBITS - 1)
    localparam int DE_TO_FE_BITS = 1;   // from_DE_to_FE carries only the stall

endpackage

// File: rtl/reg_busy_counter.sv
// -----------------------------------------------------------------------------
// reg_busy_counter
//   Pending-write counter for one architectural register. Counts up on issue,
//   down by 0..2 on retire/kill, saturating at both ends.
//
//   clk        in   pipeline clock
//   reset      in   synchronous, active-high
//   inc        in   a writing instruction to this register issues this cycle
//   dec[1:0]   in   retire + kill hits on this register this cycle (0..2)
//   cnt        out  registered count
//   nonzero    out  effective count (cnt - dec, floored) is nonzero
//   at_max     out  effective count equals the saturation value
//   underflow  out  dec exceeds cnt this cycle
//
//   nonzero/at_max describe the effective count rather than cnt, so a write
//   committing in WB this cycle no longer blocks readers in DE.
// -----------------------------------------------------------------------------
module reg_busy_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNTBITS = SB_CNTBITS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               inc,
    input  logic [1:0]         dec,
    output logic [CNTBITS-1:0] cnt,
    output logic               nonzero,
    output logic               at_max,
    output logic               underflow
);

    localparam int W = CNTBITS + 2;

    logic [CNTBITS-1:0] eff;
    logic [CNTBITS-1:0] cnt_nxt;

    // NOTE: every output of this block is given a value on every path, so
    // no latch can be inferred.
    always_comb begin
        underflow = W'(cnt) < W'(dec);
        // Without underflow dec <= cnt, so truncating dec is lossless here.
        eff       = underflow ? '0 : cnt - CNTBITS'(dec);
        nonzero   = (eff != '0);
        at_max    = &eff;
        // The top never issues into a full counter; hold anyway for safety.
        cnt_nxt   = (inc && !at_max) ? eff + CNTBITS'(1) : eff;
    end

    // NOTE: state is updated with non-blocking assignments so every flop
    // samples values from before the clock edge. The counter is a plain flop
    // rather than a memory, so it is cleared by reset like any other state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/reg_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_scoreboard
//   In-flight-write scoreboard for the DE stage. One pending-write counter per
//   architectural register (x0 excluded). DE stalls when a source operand has
//   a pending write or when the destination counter is saturated.
//
//   clk, reset     pipeline clock; synchronous active-high reset
//   src_valid      per-source read enable (NSRC bits)
//   src_regno      source register numbers, port k at [k*REGNOBITS +: REGNOBITS]
//   issue_valid    DE holds an instruction wanting to enter the DE latch
//   issue_wr/_rd   that instruction writes rd
//   retire_valid/_rd  WB commits a register write
//   kill_valid/_rd    AGEX squashes an issued writing instruction
//   stall          combinational stall to FE
//   issue_ok       issue_valid & !stall; counters take the issue only then
//   busy           per-register nonzero bitmap (1-cycle latency)
//   inflight       total of all counters (1-cycle latency)
//   err            sticky: retire or kill hit an empty counter
// -----------------------------------------------------------------------------
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NREGS     = REGWORDS,
    parameter int REGNOBITS = reg_scoreboard_pkg::REGNOBITS,
    parameter int NSRC      = 2,
    parameter int CNTBITS   = SB_CNTBITS,
    parameter int TOTBITS   = SB_TOTBITS
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NSRC-1:0]           src_valid,
    input  logic [NSRC*REGNOBITS-1:0] src_regno,
    input  logic                      issue_valid,
    input  logic                      issue_wr,
    input  logic [REGNOBITS-1:0]      issue_rd,
    input  logic                      retire_valid,
    input  logic [REGNOBITS-1:0]      retire_rd,
    input  logic                      kill_valid,
    input  logic [REGNOBITS-1:0]      kill_rd,
    output logic                      stall,
    output logic                      issue_ok,
    output logic [NREGS-1:0]          busy,
    output logic [TOTBITS-1:0]        inflight,
    output logic                      err
);

    logic [NREGS-1:0]   eff_nz;
    logic [NREGS-1:0]   eff_max;
    logic [NREGS-1:0]   uflow;
    logic [CNTBITS-1:0] cnt [NREGS];
    logic               hazard;
    logic               full;

    // x0 has no counter: it is never busy, never full, never underflows.
    assign eff_nz[0]  = 1'b0;
    assign eff_max[0] = 1'b0;
    assign uflow[0]   = 1'b0;
    assign cnt[0]     = '0;

    for (genvar r = 1; r < NREGS; r++) begin : g_reg
        logic       inc;
        logic [1:0] dec;

        assign inc = issue_ok & issue_wr & (issue_rd == REGNOBITS'(r));
        assign dec = {1'b0, retire_valid & (retire_rd == REGNOBITS'(r))}
                   + {1'b0, kill_valid   & (kill_rd   == REGNOBITS'(r))};

        reg_busy_counter #(.CNTBITS(CNTBITS)) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .inc       (inc),
            .dec       (dec),
            .cnt       (cnt[r]),
            .nonzero   (eff_nz[r]),
            .at_max    (eff_max[r]),
            .underflow (uflow[r])
        );
    end

    // Decoder form (compare against every register) avoids indexing with a
    // register number that may exceed NREGS-1 when NREGS < 2**REGNOBITS.
    always_comb begin
        hazard = 1'b0;
        full   = 1'b0;
        for (int k = 0; k < NSRC; k++) begin
            for (int r = 1; r < NREGS; r++) begin
                if (src_valid[k] &&
                    src_regno[k*REGNOBITS +: REGNOBITS] == REGNOBITS'(r) &&
                    eff_nz[r]) begin
                    hazard = 1'b1;
                end
            end
        end
        for (int r = 1; r < NREGS; r++) begin
            if (issue_wr && issue_rd == REGNOBITS'(r) && eff_max[r]) begin
                full = 1'b1;
            end
        end
    end

    assign stall    = issue_valid & (hazard | full);
    assign issue_ok = issue_valid & ~stall;

    // busy and inflight are decoded purely from counter flops: no path from
    // this cycle's inputs, and they show the post-update counts.
    always_comb begin
        inflight = '0;
        for (int r = 0; r < NREGS; r++) begin
            busy[r]  = (cnt[r] != '0);
            inflight = inflight + TOTBITS'(cnt[r]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (|uflow) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_reg_scoreboard
//   Directed vectors for reg_scoreboard with hand-computed expectations.
//   The driver applies one vector per cycle just after the rising edge and
//   queues its expected outputs; the monitor drains the queue on the falling
//   edge and compares.
// -----------------------------------------------------------------------------
module tb_reg_scoreboard;

    localparam int NREGS     = 32;
    localparam int REGNOBITS = 5;
    localparam int NSRC      = 2;
    localparam int CNTBITS   = 2;
    localparam int TOTBITS   = 7;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NSRC-1:0]           src_valid;
    logic [NSRC*REGNOBITS-1:0] src_regno;
    logic                      issue_valid;
    logic                      issue_wr;
    logic [REGNOBITS-1:0]      issue_rd;
    logic                      retire_valid;
    logic [REGNOBITS-1:0]      retire_rd;
    logic                      kill_valid;
    logic [REGNOBITS-1:0]      kill_rd;
    logic                      stall;
    logic                      issue_ok;
    logic [NREGS-1:0]          busy;
    logic [TOTBITS-1:0]        inflight;
    logic                      err;

    reg_scoreboard #(
        .NREGS(NREGS), .REGNOBITS(REGNOBITS), .NSRC(NSRC),
        .CNTBITS(CNTBITS), .TOTBITS(TOTBITS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .src_valid    (src_valid),
        .src_regno    (src_regno),
        .issue_valid  (issue_valid),
        .issue_wr     (issue_wr),
        .issue_rd     (issue_rd),
        .retire_valid (retire_valid),
        .retire_rd    (retire_rd),
        .kill_valid   (kill_valid),
        .kill_rd      (kill_rd),
        .stall        (stall),
        .issue_ok     (issue_ok),
        .busy         (busy),
        .inflight     (inflight),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        stall;
        logic        ok;
        logic [31:0] busy;
        int          inflight;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every queued expectation against the DUT outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check({e.name, ".stall"},    64'(stall),    64'(e.stall));
                check({e.name, ".issue_ok"}, 64'(issue_ok), 64'(e.ok));
                check({e.name, ".busy"},     64'(busy),     64'(e.busy));
                check({e.name, ".inflight"}, 64'(inflight), 64'(e.inflight));
                check({e.name, ".err"},      64'(err),      64'(e.err));
            end
        end
    end

    task automatic drive(input logic iv, input logic iw, input int ird,
                         input logic [1:0] sv, input int s0, input int s1,
                         input logic rv, input int rrd,
                         input logic kv, input int krd);
        issue_valid  = iv;
        issue_wr     = iw;
        issue_rd     = REGNOBITS'(ird);
        src_valid    = sv;
        src_regno    = {REGNOBITS'(s1), REGNOBITS'(s0)};
        retire_valid = rv;
        retire_rd    = REGNOBITS'(rrd);
        kill_valid   = kv;
        kill_rd      = REGNOBITS'(krd);
    endtask

    task automatic expect_vec(input string name, input logic st, input logic ok,
                              input logic [31:0] bz, input int infl, input logic er);
        exp_t e;
        e.name = name; e.stall = st; e.ok = ok; e.busy = bz; e.inflight = infl; e.err = er;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with a writing issue to x5 held active: it must be discarded.
        reset = 1'b1;
        drive(1, 1, 5, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        reset = 1'b0;

        //         iv iw rd  sv     s0 s1 rv rrd kv krd
        drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_vec("reset_state", 0, 1, 32'h0, 0, 0);                     tick();

        // RAW on x5 with same-cycle WB bypass
        drive(1, 1, 5, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_vec("raw_issue", 0, 1, 32'h0, 0, 0);                       tick();
        drive(1, 0, 0, 2'b01, 5, 0, 0, 0, 0, 0);
        expect_vec("raw_stall", 1, 0, 32'h20, 1, 0);                      tick();
        drive(1, 0, 0, 2'b01, 5, 0, 1, 5, 0, 0);
        expect_vec("raw_bypass", 0, 1, 32'h20, 1, 0);                     tick();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_vec("raw_cleared", 0, 0, 32'h0, 0, 0);                     tick();

        // x0: issue ignored, reads never stall, retire/kill ignored
        drive(1, 1, 0, 2'b11, 0, 0, 0, 0, 0, 0);
        expect_vec("x0_issue", 0, 1, 32'h0, 0, 0);                        tick();
        drive(1, 0, 0, 2'b01, 0, 0, 1, 0, 1, 0);
        expect_vec("x0_read", 0, 1, 32'h0, 0, 0);                         tick();

        // Hazard on the second read port
        drive(1, 1, 7, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_vec("x7_issue", 0, 1, 32'h0, 0, 0);                        tick();
        drive(1, 0, 0, 2'b11, 3, 7, 0, 0, 0, 0);
        expect_vec("src1_hazard", 1, 0, 32'h80, 1, 0);                    tick();
        drive(1, 0, 0, 2'b01, 3, 7, 1, 7, 0, 0);
        expect_vec("src1_invalid", 0, 1, 32'h80, 1, 0);                   tick();

        // Saturation of x9 at 3 pending writes
        drive(1, 1, 9, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_vec("sat_w1", 0, 1, 32'h0, 0, 0);                          tick();
        expect_vec("sat_w2", 0, 1, 32'h200, 1, 0);                        tick();
        expect_vec("sat_w3", 0, 1, 32'h200, 2, 0);                        tick();
        expect_vec("sat_full", 1, 0, 32'h200, 3, 0);                      tick();
        drive(1, 1, 9, 2'b00, 0, 0, 1, 9, 0, 0);
        expect_vec("sat_retire", 0, 1, 32'h200, 3, 0);                    tick();
        // Busy source but no valid instruction: no stall
        drive(0, 0, 0, 2'b01, 9, 0, 1, 9, 0, 0);
        expect_vec("sat_hold_idle", 0, 0, 32'h200, 3, 0);                 tick();
        drive(0, 0, 0, 2'b00, 0, 0, 1, 9, 0, 0);
        expect_vec("drain_2", 0, 0, 32'h200, 2, 0);                       tick();
        expect_vec("drain_1", 0, 0, 32'h200, 1, 0);                       tick();

        // Kill: issue + retire + kill on x4 with cnt=2 nets -1
        drive(1, 1, 4, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_vec("kill_w1", 0, 1, 32'h0, 0, 0);                         tick();
        expect_vec("kill_w2", 0, 1, 32'h10, 1, 0);                        tick();
        drive(1, 1, 4, 2'b00, 0, 0, 1, 4, 1, 4);
        expect_vec("kill_triple", 0, 1, 32'h10, 2, 0);                    tick();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 1, 11);
        expect_vec("kill_after", 0, 0, 32'h10, 1, 0);                     tick();

        // Underflow on x11: err sets and stays set
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_vec("uflow_err", 0, 0, 32'h10, 1, 1);                      tick();
        drive(0, 0, 0, 2'b00, 0, 0, 1, 4, 0, 0);
        expect_vec("uflow_sticky", 0, 0, 32'h10, 1, 1);                   tick();
        drive(1, 1, 6, 2'b00, 0, 0, 0, 0, 0, 0);
        expect_vec("uflow_sticky2", 0, 1, 32'h0, 0, 1);                   tick();

        // Mid-operation reset with an active writing issue
        reset = 1'b1;
        drive(1, 1, 6, 2'b00, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(1, 0, 0, 2'b01, 6, 0, 0, 0, 0, 0);
        expect_vec("mid_reset", 0, 1, 32'h0, 0, 0);                       tick();
        drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

        // Bounded wait for the monitor to drain the queue.
        for (int i = 0; i < 4 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
